seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Recovers a 4-digit hexadecimal value from a multiplexed, active-low
// seven-segment display scan. Each digit must be held steady for
// STABLE_CYCLES registered samples before it is captured. A frame is
// published on o_value once all four digits have been captured.
module seg_scan_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [3:0]  i_digitSelect,
   input  logic [6:0]  i_seg,
   output logic [15:0] o_value,
   output logic        o_valid,
   output logic        o_err,
   output logic [3:0]  o_digitMask
);

   localparam int          CNT_W     = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [3:0]  SEL_IDLE  = 4'hF;
   localparam logic [6:0]  SEG_IDLE  = 7'h7F;

   // Segment pattern (active-high, gfedcba) to nibble. Bit 4 flags a
   // pattern that is not one of the sixteen hex glyphs.
   function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
      logic [4:0] res;
      case (pat)
         7'h3F:   res = 5'h00;
         7'h06:   res = 5'h01;
         7'h5B:   res = 5'h02;
         7'h4F:   res = 5'h03;
         7'h66:   res = 5'h04;
         7'h6D:   res = 5'h05;
         7'h7D:   res = 5'h06;
         7'h07:   res = 5'h07;
         7'h7F:   res = 5'h08;
         7'h6F:   res = 5'h09;
         7'h77:   res = 5'h0A;
         7'h7C:   res = 5'h0B;
         7'h39:   res = 5'h0C;
         7'h5E:   res = 5'h0D;
         7'h79:   res = 5'h0E;
         7'h71:   res = 5'h0F;
         default: res = 5'h10;
      endcase
      return res;
   endfunction

   // Input sample (S) and the sample before it.
   logic [3:0]       sel_q,      sel_d;
   logic [6:0]       seg_q,      seg_d;
   logic [3:0]       sel_prev_q, sel_prev_d;
   logic [6:0]       seg_prev_q, seg_prev_d;

   // Dwell tracking.
   logic [CNT_W-1:0] cnt_q,      cnt_d;

   // Frame assembly.
   logic [15:0]      shadow_q,   shadow_d;
   logic [3:0]       mask_q,     mask_d;
   logic             ferr_q,     ferr_d;

   // Published outputs.
   logic [15:0]      value_q,    value_d;
   logic             err_q,      err_d;
   logic             valid_q,    valid_d;

   // Derived per-cycle signals.
   logic [3:0]       sel_low;
   logic             sample_valid;
   logic             sample_same;
   logic             capture;
   logic [1:0]       dig_idx;
   logic [4:0]       glyph;
   logic [3:0]       cap_nib;
   logic             cap_bad;
   logic [3:0]       mask_cap;
   logic             ferr_cap;

   assign sel_low      = ~sel_q;
   // Exactly one select line low: non-zero and a power of two.
   assign sample_valid = (sel_low != 4'd0) && ((sel_low & (sel_low - 4'd1)) == 4'd0);
   assign sample_same  = (sel_q == sel_prev_q) && (seg_q == seg_prev_q);

   assign glyph   = decode_glyph(~seg_q);
   assign cap_bad = glyph[4];
   assign cap_nib = glyph[4] ? 4'h0 : glyph[3:0];

   // Pipeline the raw buses so decoding only ever sees registered samples.
   always_comb begin
      sel_d      = i_digitSelect;
      seg_d      = i_seg;
      sel_prev_d = sel_q;
      seg_prev_d = seg_q;
   end

   // Dwell counter: saturating run length of identical valid samples.
   always_comb begin
      cnt_d = cnt_q;
      if (!sample_valid) begin
         cnt_d = '0;
      end else if (sample_same) begin
         cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
      end else begin
         cnt_d = CNT_W'(1);
      end
   end

   // Capture fires only on the edge the run first becomes long enough.
   assign capture = sample_valid && (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);

   // One-hot-low select to digit index; only meaningful when sample_valid.
   always_comb begin
      dig_idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (sel_low[i]) dig_idx = 2'(i);
      end
   end

   // Per-digit shadow nibble update; the latest capture of a digit wins.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
         assign shadow_d[4*gi +: 4] = (capture && (dig_idx == 2'(gi)))
                                      ? cap_nib : shadow_q[4*gi +: 4];
      end
   endgenerate

   assign mask_cap = mask_q | (4'b0001 << dig_idx);
   assign ferr_cap = ferr_q | cap_bad;

   // Frame bookkeeping and publication of a completed frame.
   always_comb begin
      mask_d  = mask_q;
      ferr_d  = ferr_q;
      value_d = value_q;
      err_d   = err_q;
      valid_d = 1'b0;
      if (capture) begin
         if (mask_cap == 4'hF) begin
            value_d = shadow_d;
            err_d   = ferr_cap;
            valid_d = 1'b1;
            mask_d  = 4'h0;
            ferr_d  = 1'b0;
         end else begin
            mask_d  = mask_cap;
            ferr_d  = ferr_cap;
         end
      end
   end

   // Sample registers; reset to the "nothing selected, all segments off" idle state.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         sel_q      <= SEL_IDLE;
         seg_q      <= SEG_IDLE;
         sel_prev_q <= SEL_IDLE;
         seg_prev_q <= SEG_IDLE;
      end else begin
         sel_q      <= sel_d;
         seg_q      <= seg_d;
         sel_prev_q <= sel_prev_d;
         seg_prev_q <= seg_prev_d;
      end
   end

   // Dwell counter register.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Frame state and output registers; reset discards any partial frame.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         shadow_q <= '0;
         mask_q   <= '0;
         ferr_q   <= 1'b0;
         value_q  <= '0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         mask_q   <= mask_d;
         ferr_q   <= ferr_d;
         value_q  <= value_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
      end
   end

   assign o_value     = value_q;
   assign o_err       = err_q;
   assign o_valid     = valid_q;
   assign o_digitMask = mask_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
// Scoreboard bench: the driver feeds a run-length model of the display
// scan, which queues the frames it expects; a negedge monitor pops and
// compares whenever o_valid is seen and checks hold/reset behaviour otherwise.
module tb_seg_scan_decoder;

   localparam int STABLE = 4;

   logic        clk = 1'b0;
   logic        i_rst;
   logic [3:0]  i_digitSelect;
   logic [6:0]  i_seg;
   logic [15:0] o_value;
   logic        o_valid;
   logic        o_err;
   logic [3:0]  o_digitMask;

   seg_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_digitSelect (i_digitSelect),
      .i_seg         (i_seg),
      .o_value       (o_value),
      .o_valid       (o_valid),
      .o_err         (o_err),
      .o_digitMask   (o_digitMask)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] value;
      logic        err;
   } frame_t;

   frame_t      exp_q[$];
   int          n_vec  = 0;
   int          n_fail = 0;
   logic [15:0] last_value = '0;
   logic        last_err   = 1'b0;

   // Reference model state: run length of identical inputs and the frame being built.
   logic [3:0]  m_prev_sel;
   logic [6:0]  m_prev_seg;
   int          m_run;
   logic [3:0]  m_mask;
   logic        m_err;
   logic [3:0]  m_nib [4];

   // Active-high gfedcba glyph for a hex value.
   function automatic logic [6:0] glyph(input int v);
      logic [6:0] g;
      case (v)
         0: g = 7'h3F;  1: g = 7'h06;  2: g = 7'h5B;  3: g = 7'h4F;
         4: g = 7'h66;  5: g = 7'h6D;  6: g = 7'h7D;  7: g = 7'h07;
         8: g = 7'h7F;  9: g = 7'h6F; 10: g = 7'h77; 11: g = 7'h7C;
        12: g = 7'h39; 13: g = 7'h5E; 14: g = 7'h79; default: g = 7'h71;
      endcase
      return g;
   endfunction

   // Value shown by an active-low segment bus, or -1 if it is no hex glyph.
   function automatic int lookup(input logic [6:0] seg_low);
      logic [6:0] hi;
      hi = ~seg_low;
      for (int v = 0; v < 16; v++) begin
         if (glyph(v) == hi) return v;
      end
      return -1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_prev_sel = 4'hF;
      m_prev_seg = 7'h7F;
      m_run      = 0;
      m_mask     = 4'h0;
      m_err      = 1'b0;
      for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
   endtask

   // One cycle of input seen by the model: a digit is captured when the
   // same valid pair has been presented for exactly STABLE cycles in a row.
   task automatic model_step(input logic [3:0] s, input logic [6:0] g);
      logic [3:0] low;
      int         d;
      int         v;
      low = ~s;
      if ($countones(low) != 1) begin
         m_run = 0;
      end else if (s == m_prev_sel && g == m_prev_seg) begin
         m_run++;
      end else begin
         m_run = 1;
      end
      m_prev_sel = s;
      m_prev_seg = g;
      if ($countones(low) == 1 && m_run == STABLE) begin
         d = 0;
         for (int i = 0; i < 4; i++) if (low[i]) d = i;
         v = lookup(g);
         if (v < 0) begin
            m_nib[d] = 4'h0;
            m_err    = 1'b1;
         end else begin
            m_nib[d] = 4'(v);
         end
         m_mask[d] = 1'b1;
         if (m_mask == 4'hF) begin
            exp_q.push_back('{value: {m_nib[3], m_nib[2], m_nib[1], m_nib[0]}, err: m_err});
            m_mask = 4'h0;
            m_err  = 1'b0;
         end
      end
   endtask

   task automatic cyc(input logic [3:0] s, input logic [6:0] g);
      i_digitSelect = s;
      i_seg         = g;
      model_step(s, g);
      @(posedge clk);
      #1;
   endtask

   task automatic show_raw(input int digit, input logic [6:0] seg_low, input int hold);
      logic [3:0] s;
      s = 4'b0001 << digit;
      s = ~s;
      repeat (hold) cyc(s, seg_low);
   endtask

   task automatic show(input int digit, input int value, input int hold);
      logic [6:0] g;
      g = glyph(value);
      show_raw(digit, ~g, hold);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(4'hF, 7'h7F);
   endtask

   task automatic do_reset(input int n);
      check("pending_before_reset", 32'(exp_q.size()), 32'd0);
      i_rst         = 1'b0;
      i_digitSelect = 4'hF;
      i_seg         = 7'h7F;
      model_reset();
      repeat (n) @(posedge clk);
      #1;
      i_rst = 1'b1;
   endtask

   // Monitor: reset forces zeros; o_valid pops the scoreboard; otherwise outputs hold.
   always @(negedge clk) begin
      if (!i_rst) begin
         check("rst_value", 32'(o_value), 32'd0);
         check("rst_valid", 32'(o_valid), 32'd0);
         check("rst_err",   32'(o_err),   32'd0);
         check("rst_mask",  32'(o_digitMask), 32'd0);
         last_value <= '0;
         last_err   <= 1'b0;
      end else if (o_valid) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_valid: got o_value %0h with no frame expected at %0t", o_value, $time);
         end else begin
            frame_t f;
            f = exp_q.pop_front();
            check("frame_value", 32'(o_value), 32'(f.value));
            check("frame_err",   32'(o_err),   32'(f.err));
            last_value <= f.value;
            last_err   <= f.err;
         end
      end else begin
         check("hold_value", 32'(o_value), 32'(last_value));
         check("hold_err",   32'(o_err),   32'(last_err));
      end
   end

   // Global time bound so the bench can never hang.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, %0d frames still pending", exp_q.size());
      $fatal(1, "timeout");
   end

   initial begin
      i_rst         = 1'b0;
      i_digitSelect = 4'hF;
      i_seg         = 7'h7F;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      i_rst = 1'b1;
      idle(2);

      // Basic scan 1,2,3,4 on digits 0..3, each held exactly STABLE cycles.
      show_raw(0, 7'h79, 4);
      show_raw(1, 7'h24, 4);
      show_raw(2, 7'h30, 4);
      show_raw(3, 7'h19, 4);
      idle(4);
      check("scan_value", 32'(o_value), 32'h4321);
      check("scan_err",   32'(o_err),   32'd0);
      check("scan_mask",  32'(o_digitMask), 32'd0);

      // Every digit held one cycle short: nothing may be captured.
      for (int t = 0; t < 40; t++) begin
         show((t / 3) % 4, (t / 3) % 16, 1);
         check("short_mask", 32'(o_digitMask), 32'd0);
      end
      idle(3);
      check("short_mask_end", 32'(o_digitMask), 32'd0);

      // Undecodable pattern on digit 2 (segment a alone is not a hex glyph).
      show(0, 0, 4);
      show(1, 0, 4);
      show_raw(2, 7'h7E, 4);
      show(3, 0, 4);
      idle(4);
      check("bad_value", 32'(o_value), 32'h0000);
      check("bad_err",   32'(o_err),   32'd1);
      show(0, 5, 4);
      show(1, 6, 4);
      show(2, 7, 4);
      show(3, 8, 4);
      idle(4);
      check("clean_value", 32'(o_value), 32'h8765);
      check("clean_err",   32'(o_err),   32'd0);

      // Invalid selects between digits, and a dwell interrupted by one.
      show(0, 1, 4);
      repeat (10) cyc(4'b1100, 7'h00);
      show(1, 2, 4);
      idle(10);
      show(2, 3, 2);
      repeat (3) cyc(4'b1100, 7'h00);
      show(2, 3, 2);
      idle(3);
      check("invalid_mask", 32'(o_digitMask), 32'h3);
      show(2, 3, 4);
      show(3, 4, 4);
      idle(4);
      check("invalid_value", 32'(o_value), 32'h4321);

      // Reset after two captures discards them.
      show(0, 1, 4);
      show(1, 2, 4);
      idle(3);
      check("pre_reset_mask", 32'(o_digitMask), 32'h3);
      do_reset(4);
      show(2, 11, 4);
      show(3, 12, 4);
      idle(3);
      check("post_reset_mask",  32'(o_digitMask), 32'hC);
      check("post_reset_value", 32'(o_value), 32'h0);
      show(0, 9, 4);
      show(1, 10, 4);
      idle(4);
      check("post_reset_frame", 32'(o_value), 32'hCBA9);

      // Digit 1 recaptured: latest nibble wins.
      show(1, 5, 4);
      show(1, 7, 4);
      idle(3);
      check("recap_mask", 32'(o_digitMask), 32'h2);
      show(0, 3, 4);
      show(2, 14, 4);
      show(3, 15, 4);
      idle(4);
      check("recap_value", 32'(o_value), 32'hFE73);

      // Randomized scan with ghosts, invalid selects and odd patterns.
      for (int n = 0; n < 300; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 5) begin
            show($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(1, 7));
         end else if (r == 6) begin
            logic [3:0] s;
            s = ($urandom_range(0, 1) == 0) ? 4'hF : 4'(($urandom_range(0, 5) == 0) ? 4'h0 : 4'b0101);
            repeat ($urandom_range(1, 4)) cyc(s, 7'($urandom));
         end else if (r == 7) begin
            show_raw($urandom_range(0, 3), 7'($urandom), $urandom_range(4, 5));
         end else begin
            show_raw($urandom_range(0, 3), 7'($urandom), 1);
         end
      end
      idle(10);
      check("pending_at_end", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
